mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 64-bit memory port between the IF stage (instruction read) and the MEM stage (load/store).
//  Serialises accesses: one outstanding transaction, then routes the response back to its owner.
//  MEM has priority, with a starvation guard for IF.
//  Sits between the pipeline (IF, MEM) and the memory/bus model; adds a response timeout and IF-flush drop.
// PARAMETERS
//  ADDR_W       32   address width, both requesters and bus
//  STARVE_MAX   4    consecutive MEM grants while IF waits before IF is forced
//  TIMEOUT_CYC  255  WAIT cycles before an error response is generated (>=1)
// PORTS
//  clock          in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  if_req_valid   in   1       IF fetch request
//  if_req_ready   out  1       IF request accepted this cycle
//  if_req_addr    in   ADDR_W  fetch address (4-byte aligned)
//  if_flush       in   1       mispredict: discard IF request/response in flight
//  if_rsp_valid   out  1       one-cycle pulse: instruction returned
//  if_rsp_instr   out  32      instruction: word selected by latched addr[2]
//  if_rsp_err     out  1       IF response is a timeout error
//  mem_req_valid  in   1       MEM-stage request
//  mem_req_ready  out  1       MEM request accepted this cycle
//  mem_req_wr     in   1       1 = store, 0 = load
//  mem_req_addr   in   ADDR_W  data address
//  mem_req_wdata  in   64      store data
//  mem_req_wmask  in   8       byte-enable mask
//  mem_rsp_valid  out  1       one-cycle pulse: load data / store ack
//  mem_rsp_data   out  64      load data (0 for stores)
//  mem_rsp_err    out  1       MEM response is a timeout error
//  bus_req_valid  out  1       request to memory port
//  bus_req_ready  in   1       memory accepts request
//  bus_req_wr     out  1       latched wr
//  bus_req_addr   out  ADDR_W  latched address
//  bus_req_wdata  out  64      latched store data
//  bus_req_wmask  out  8       latched mask; 8'h00 for IF reads
//  bus_rsp_valid  in   1       memory response (read data / write ack)
//  bus_rsp_data   in   64      memory read data
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: bus_*, *_rsp_*, *_req_ready. starve_cnt=0, drop=0, timeout counter=0.
//  FSM IDLE -> REQ -> WAIT -> IDLE.
//  IDLE grant (combinational ready, single cycle):
//    - mem_req_valid && !(if_req_valid && starve_cnt==STARVE_MAX) -> grant MEM.
//    - else if_req_valid && !if_flush -> grant IF.
//    - Exactly one *_req_ready=1 for the granted side; the request is latched, owner recorded, next state REQ.
//    - *_req_ready is 0 in REQ/WAIT.
//  starve_cnt:
//    - +1 on each MEM grant with if_req_valid=1, saturating at STARVE_MAX.
//    - Cleared on IF grant, and in IDLE when if_req_valid=0.
//  REQ: bus_req_valid=1 with the latched fields, held stable until bus_req_ready; then -> WAIT (bus_req_valid=0 next cycle).
//  WAIT:
//    - Counter counts cycles.
//    - bus_rsp_valid -> latch response; owner's rsp_valid pulses 1 cycle later; -> IDLE.
//    - Counter hits TIMEOUT_CYC without bus_rsp_valid -> owner gets rsp_valid=1, err=1, data=0; -> IDLE.
//    - bus_rsp_valid in the same cycle as the timeout: the real response wins, err=0.
//  Throughput: the rsp pulse cycle is an IDLE cycle, so a new grant can occur in the same cycle.
//    Minimum 3 cycles per access: grant, REQ, WAIT with an immediate response.
//  IF flush:
//    - if_flush=1 while the owner is IF in REQ/WAIT sets drop. The bus transaction still completes; it is never abandoned mid-handshake.
//    - Its response, including a timeout, is suppressed: if_rsp_valid stays 0.
//    - drop clears on return to IDLE. if_flush has no effect on a MEM-owned transaction.
//  Stores: wait for bus_rsp_valid as the ack; mem_rsp_data=0.
//  if_rsp_instr = addr[2] ? bus_rsp_data[63:32] : bus_rsp_data[31:0], using the latched address.
//  bus_rsp_valid in IDLE/REQ (spurious) is ignored.
//  Reset mid-transaction returns to IDLE immediately; the memory side is reset together with this block.
// TESTING
//  1. Only if_req_valid, addr=0x80000004, bus returns 0x11223344_AABBCCDD after 2 cycles
//     -> if_rsp_valid pulse, instr=0x11223344, err=0, bus_req_wmask=0.
//  2. if_req_valid and mem_req_valid both held continuously -> grant order MEM x4, IF, MEM x4, IF (STARVE_MAX=4).
//  3. MEM store addr=0x80001000, wdata=0xDEAD, wmask=0x0F, bus_req_ready delayed 3 cycles
//     -> bus fields stable across the stall; mem_rsp_valid after the ack, data=0.
//  4. IF fetch, if_flush pulsed in WAIT -> bus completes, if_rsp_valid never asserted; next MEM request is granted normally.
//  5. TIMEOUT_CYC=8, bus never responds to a MEM load -> mem_rsp_valid=1, mem_rsp_err=1, data=0 after 8 WAIT cycles; FSM returns to IDLE.
//  6. Assert reset during WAIT -> next cycle all outputs 0, state IDLE; a fresh IF request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory-port arbiter, the IF/MEM pipeline stages and the memory bus.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_instr;
  logic              if_rsp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wr;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [63:0]       mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_data;
  logic              mem_rsp_err;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_wr;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [63:0]       bus_req_wdata;
  logic [7:0]        bus_req_wmask;
  logic              bus_rsp_valid;
  logic [63:0]       bus_rsp_data;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_instr, if_rsp_err,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output bus_req_valid, bus_req_wr, bus_req_addr, bus_req_wdata, bus_req_wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output bus_req_ready, bus_rsp_valid, bus_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_instr, if_rsp_err,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  bus_req_valid, bus_req_wr, bus_req_addr, bus_req_wdata, bus_req_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between IF fetches and MEM loads/stores, one transaction at a time.
// MEM wins arbitration unless IF has waited STARVE_MAX grants; WAIT has a response timeout.
//
//   state  | meaning
//   S_IDLE | no transaction; combinational grant, response pulse of the previous access
//   S_REQ  | latched request presented on the bus until accepted
//   S_WAIT | waiting for bus response or timeout
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   port
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              grant_mem, grant_if, rsp_done, tmr_tc;
  logic              owner_if, drop;
  logic [SW-1:0]     starve_cnt;
  logic [TW-1:0]     tmr;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0]       lat_wdata;
  logic [7:0]        lat_wmask;
  logic              if_rv, if_err, mem_rv, mem_err;
  logic [31:0]       if_instr;
  logic [63:0]       mem_data;

  // Grant is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state == S_IDLE && !reset) begin
      if (port.mem_req_valid && !(port.if_req_valid && starve_cnt == STARVE_LIM))
        grant_mem = 1'b1;
      else if (port.if_req_valid && !port.if_flush)
        grant_if = 1'b1;
    end
  end

  assign tmr_tc   = (tmr == '0);
  assign rsp_done = (state == S_WAIT) && (port.bus_rsp_valid || tmr_tc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_mem || grant_if) state_nxt = S_REQ;
      S_REQ:   if (port.bus_req_ready)    state_nxt = S_WAIT;
      S_WAIT:  if (rsp_done)              state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    port.if_req_ready  = grant_if;
    port.mem_req_ready = grant_mem;
    port.bus_req_valid = (state == S_REQ);
  end

  assign port.bus_req_wr    = lat_wr;
  assign port.bus_req_addr  = lat_addr;
  assign port.bus_req_wdata = lat_wdata;
  assign port.bus_req_wmask = lat_wmask;
  assign port.if_rsp_valid  = if_rv;
  assign port.if_rsp_instr  = if_instr;
  assign port.if_rsp_err    = if_err;
  assign port.mem_rsp_valid = mem_rv;
  assign port.mem_rsp_data  = mem_data;
  assign port.mem_rsp_err   = mem_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_if   <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      tmr        <= '0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      if_rv      <= 1'b0;
      if_err     <= 1'b0;
      if_instr   <= '0;
      mem_rv     <= 1'b0;
      mem_err    <= 1'b0;
      mem_data   <= '0;
    end else begin
      if_rv    <= 1'b0;
      if_err   <= 1'b0;
      if_instr <= '0;
      mem_rv   <= 1'b0;
      mem_err  <= 1'b0;
      mem_data <= '0;

      if (grant_mem || grant_if) begin
        owner_if  <= grant_if;
        lat_wr    <= grant_mem && port.mem_req_wr;
        lat_addr  <= grant_mem ? port.mem_req_addr  : port.if_req_addr;
        lat_wdata <= grant_mem ? port.mem_req_wdata : 64'h0;
        lat_wmask <= grant_mem ? port.mem_req_wmask : 8'h00;
      end

      if (state == S_REQ && port.bus_req_ready) tmr <= TMR_LOAD;
      else if (state == S_WAIT && !tmr_tc)      tmr <= tmr - 1'b1;

      if (grant_if)
        starve_cnt <= '0;
      else if (grant_mem && port.if_req_valid) begin
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
      end else if (state == S_IDLE && !port.if_req_valid)
        starve_cnt <= '0;

      if (state == S_IDLE)                drop <= 1'b0;
      else if (owner_if && port.if_flush) drop <= 1'b1;

      // A flush arriving in the completing cycle suppresses the response too.
      if (rsp_done) begin
        if (owner_if) begin
          if (!(drop || port.if_flush)) begin
            if_rv  <= 1'b1;
            if_err <= !port.bus_rsp_valid;
            if (port.bus_rsp_valid)
              if_instr <= lat_addr[2] ? port.bus_rsp_data[63:32] : port.bus_rsp_data[31:0];
          end
        end else begin
          mem_rv  <= 1'b1;
          mem_err <= !port.bus_rsp_valid;
          if (port.bus_rsp_valid && !lat_wr) mem_data <= port.bus_rsp_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter_if #(.ADDR_W(32)) bif ();

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)) dut (
    .clock(clock),
    .reset(reset),
    .port (bif)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic         ifv;
    logic [31:0]  ifa;
    logic         mv;
    logic         mwr;
    logic [31:0]  ma;
    logic [7:0]   mwm;
    logic         brdy;
    logic         brv;
    logic [63:0]  brd;
    logic [142:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [142:0] ex(logic ifr, logic mr, logic bv, logic [31:0] ba, logic [7:0] bm,
                                      logic irv, logic [31:0] ins, logic ie,
                                      logic mrv, logic [63:0] md, logic me);
    return {ifr, mr, bv, ba, bm, irv, ins, ie, mrv, md, me};
  endfunction

  // Bus fields only matter while valid; response fields only during their pulse.
  function automatic logic [142:0] obs();
    return {bif.if_req_ready, bif.mem_req_ready, bif.bus_req_valid,
            bif.bus_req_valid ? bif.bus_req_addr : 32'h0,
            bif.bus_req_valid ? bif.bus_req_wmask : 8'h0,
            bif.if_rsp_valid,
            bif.if_rsp_valid ? bif.if_rsp_instr : 32'h0,
            bif.if_rsp_valid ? bif.if_rsp_err : 1'b0,
            bif.mem_rsp_valid,
            bif.mem_rsp_valid ? bif.mem_rsp_data : 64'h0,
            bif.mem_rsp_valid ? bif.mem_rsp_err : 1'b0};
  endfunction

  function automatic logic [207:0] all_outs();
    return {bif.if_req_ready, bif.mem_req_ready, bif.if_rsp_valid, bif.if_rsp_instr, bif.if_rsp_err,
            bif.mem_rsp_valid, bif.mem_rsp_data, bif.mem_rsp_err, bif.bus_req_valid, bif.bus_req_wr,
            bif.bus_req_addr, bif.bus_req_wdata, bif.bus_req_wmask};
  endfunction

  function automatic vec_t mk(string n, logic ifv, logic [31:0] ifa, logic mv, logic [31:0] ma,
                              logic [7:0] mwm, logic brdy, logic brv, logic [63:0] brd, logic [142:0] e);
    vec_t v;
    v.name = n; v.ifv = ifv; v.ifa = ifa; v.mv = mv; v.mwr = 1'b0; v.ma = ma; v.mwm = mwm;
    v.brdy = brdy; v.brv = brv; v.brd = brd; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, logic [207:0] got, logic [207:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bif.if_req_valid = 1'b0; bif.if_req_addr = 32'h0; bif.if_flush = 1'b0;
    bif.mem_req_valid = 1'b0; bif.mem_req_wr = 1'b0; bif.mem_req_addr = 32'h0;
    bif.mem_req_wdata = 64'h0; bif.mem_req_wmask = 8'h0;
    bif.bus_req_ready = 1'b0; bif.bus_rsp_valid = 1'b0; bif.bus_rsp_data = 64'h0;
  endtask

  task automatic mem_load(logic [31:0] a);
    bif.mem_req_valid = 1'b1; bif.mem_req_wr = 1'b0; bif.mem_req_addr = a; bif.mem_req_wmask = 8'hFF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [142:0] Z = '0;
    logic [9:0] grants;
    int n_grant;
    logic both;
    int pulse_at;
    logic [65:0] to_seen;

    tbl[0]  = mk("t1_if_grant",     1'b1, 32'h80000004, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                 ex(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl[1]  = mk("t1_if_req",       1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                 ex(1'b0, 1'b0, 1'b1, 32'h80000004, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl[2]  = mk("t1_if_wait",      1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 64'h0, Z);
    tbl[3]  = mk("t1_if_wait_rsp",  1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 64'h11223344_AABBCCDD, Z);
    tbl[4]  = mk("t1_rsp_mem_grant", 1'b0, 32'h0, 1'b1, 32'h80000010, 8'hFF, 1'b0, 1'b0, 64'h0,
                 ex(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b1, 32'h11223344, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl[5]  = mk("ld_req",          1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                 ex(1'b0, 1'b0, 1'b1, 32'h80000010, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl[6]  = mk("ld_wait_rsp",     1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 64'hCAFEBABE_12345678, Z);
    tbl[7]  = mk("ld_rsp_if_grant", 1'b1, 32'h80000008, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                 ex(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hCAFEBABE_12345678, 1'b0));
    tbl[8]  = mk("if_req_spurious", 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 64'hDEADDEAD_DEADDEAD,
                 ex(1'b0, 1'b0, 1'b1, 32'h80000008, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl[9]  = mk("if_wait_rsp_lo",  1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 64'h55555555_66666666, Z);
    tbl[10] = mk("if_rsp_lo",       1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                 ex(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h66666666, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl[11] = mk("idle_spurious",   1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 64'h77777777_88888888, Z);
    tbl[12] = mk("idle_quiet",      1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 64'h0, Z);

    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", all_outs(), '0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      bif.if_req_valid = tbl[i].ifv; bif.if_req_addr = tbl[i].ifa;
      bif.mem_req_valid = tbl[i].mv; bif.mem_req_wr = tbl[i].mwr;
      bif.mem_req_addr = tbl[i].ma; bif.mem_req_wmask = tbl[i].mwm;
      bif.bus_req_ready = tbl[i].brdy; bif.bus_rsp_valid = tbl[i].brv; bif.bus_rsp_data = tbl[i].brd;
      #1;
      chk(tbl[i].name, {65'h0, obs()}, {65'h0, tbl[i].exp});
      tick();
    end
    idle_inputs();

    // Starvation guard: both requesters held, bus answers immediately.
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h80000100;
    mem_load(32'h80000200);
    bif.bus_req_ready = 1'b1; bif.bus_rsp_valid = 1'b1;
    grants = '0; n_grant = 0; both = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bif.if_req_ready && bif.mem_req_ready) both = 1'b1;
      if ((bif.if_req_ready || bif.mem_req_ready) && n_grant < 10) begin
        grants[n_grant] = bif.if_req_ready;
        n_grant++;
      end
      tick();
    end
    chk("starve_count", 208'(n_grant), 208'd10);
    chk("starve_order", {198'h0, grants}, {198'h0, 10'b10000_10000});
    chk("starve_exclusive", {207'h0, both}, '0);
    bif.if_req_valid = 1'b0; bif.mem_req_valid = 1'b0;
    repeat (3) tick();
    idle_inputs();
    tick();

    // Store with a 3-cycle bus stall.
    bif.mem_req_valid = 1'b1; bif.mem_req_wr = 1'b1; bif.mem_req_addr = 32'h80001000;
    bif.mem_req_wdata = 64'hDEAD; bif.mem_req_wmask = 8'h0F;
    #1;
    chk("st_grant", {206'h0, bif.mem_req_ready, bif.if_req_ready}, {206'h0, 2'b10});
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      bif.bus_req_ready = (k == 3);
      #1;
      chk(k == 3 ? "st_accept" : "st_stall",
          {102'h0, bif.bus_req_valid, bif.bus_req_wr, bif.bus_req_addr, bif.bus_req_wdata, bif.bus_req_wmask},
          {102'h0, 1'b1, 1'b1, 32'h80001000, 64'hDEAD, 8'h0F});
      tick();
    end
    bif.bus_req_ready = 1'b0; bif.bus_rsp_valid = 1'b1; bif.bus_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("st_wait", {207'h0, bif.bus_req_valid}, '0);
    tick();
    idle_inputs();
    #1;
    chk("st_ack", {142'h0, bif.mem_rsp_valid, bif.mem_rsp_data, bif.mem_rsp_err}, {142'h0, 1'b1, 64'h0, 1'b0});
    tick();

    // IF flush while waiting: response dropped, MEM proceeds.
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h80000020;
    #1;
    chk("fl_if_grant", {207'h0, bif.if_req_ready}, {207'h0, 1'b1});
    tick();
    bif.if_req_valid = 1'b0; bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0; bif.if_flush = 1'b1;
    tick();
    bif.if_flush = 1'b0; bif.bus_rsp_valid = 1'b1; bif.bus_rsp_data = 64'h12345678_9ABCDEF0;
    tick();
    bif.bus_rsp_valid = 1'b0;
    mem_load(32'h80000030);
    #1;
    chk("fl_suppress_mem_grant", {206'h0, bif.if_rsp_valid, bif.mem_req_ready}, {206'h0, 2'b01});
    tick();
    idle_inputs(); bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0; bif.bus_rsp_valid = 1'b1; bif.bus_rsp_data = 64'h01234567_89ABCDEF;
    tick();
    idle_inputs();
    #1;
    chk("fl_mem_rsp", {142'h0, bif.mem_rsp_valid, bif.mem_rsp_data, bif.if_rsp_valid},
        {142'h0, 1'b1, 64'h01234567_89ABCDEF, 1'b0});
    tick();

    // Response arrives on the last WAIT cycle: real data wins over timeout.
    mem_load(32'h80000050);
    #1;
    chk("race_grant", {207'h0, bif.mem_req_ready}, {207'h0, 1'b1});
    tick();
    idle_inputs(); bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0;
    repeat (7) tick();
    bif.bus_rsp_valid = 1'b1; bif.bus_rsp_data = 64'h0BADF00D_0BADF00D;
    tick();
    idle_inputs();
    #1;
    chk("to_race", {142'h0, bif.mem_rsp_valid, bif.mem_rsp_err, bif.mem_rsp_data},
        {142'h0, 1'b1, 1'b0, 64'h0BADF00D_0BADF00D});
    tick();

    // Timeout: bus never answers a MEM load.
    mem_load(32'h80000040);
    #1;
    chk("to_grant", {207'h0, bif.mem_req_ready}, {207'h0, 1'b1});
    tick();
    idle_inputs(); bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0;
    pulse_at = 0; to_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (bif.mem_rsp_valid) begin
        pulse_at = k;
        to_seen = {1'b1, bif.mem_rsp_err, bif.mem_rsp_data};
        break;
      end
      tick();
    end
    chk("to_latency", 208'(pulse_at), 208'd9);
    chk("to_err", {142'h0, to_seen}, {142'h0, 1'b1, 1'b1, 64'h0});
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h80000044;
    #1;
    chk("to_idle_grant", {207'h0, bif.if_req_ready}, {207'h0, 1'b1});
    tick();

    // Reset in WAIT, then a fresh fetch.
    bif.if_req_valid = 1'b0; bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0;
    tick();
    bif.if_req_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_outputs", all_outs(), '0);
    tick();
    chk("rst_held", all_outs(), '0);
    reset = 1'b0;
    #1;
    chk("rst_fresh_grant", {207'h0, bif.if_req_ready}, {207'h0, 1'b1});
    tick();
    bif.if_req_valid = 1'b0; bif.bus_req_ready = 1'b1;
    #1;
    chk("rst_fresh_req", {167'h0, bif.bus_req_valid, bif.bus_req_addr, bif.bus_req_wmask},
        {167'h0, 1'b1, 32'h80000044, 8'h00});
    tick();
    bif.bus_req_ready = 1'b0; bif.bus_rsp_valid = 1'b1; bif.bus_rsp_data = 64'hA5A5A5A5_5A5A5A5A;
    tick();
    idle_inputs();
    #1;
    chk("rst_fresh_rsp", {174'h0, bif.if_rsp_valid, bif.if_rsp_instr, bif.if_rsp_err},
        {174'h0, 1'b1, 32'hA5A5A5A5, 1'b0});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
